// File: rtl/free_list_pkg.sv
// Shared rename-stage sizing: physical register file geometry and free-list pointer width.
// Other blocks (e.g. ROB checkpointing) import FL_PTR_W to store free-list pointers.
package free_list_pkg;

  localparam int PHYS_REG_SZ     = 64;
  localparam int PHYS_REG_IDX_SZ = $clog2(PHYS_REG_SZ) - 1;
  localparam int PR_W            = PHYS_REG_IDX_SZ + 1;
  localparam logic [PHYS_REG_IDX_SZ:0] ZERO_REG = '0;
  localparam int FL_PTR_W        = $clog2(PHYS_REG_SZ) + 1;

endpackage

// File: rtl/free_list.sv
// Physical register free list: circular buffer with speculative head, retired head and tail.
// Allocation reads the head entry combinationally; a mispredict rewinds head to the retired head.
module free_list
  import free_list_pkg::*;
#(
  parameter int FL_SZ = PHYS_REG_SZ,
  parameter int PTR_W = $clog2(FL_SZ) + 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_req,
  output logic                     alloc_valid,
  output logic [PHYS_REG_IDX_SZ:0] alloc_pr_idx,
  input  logic                     free_enable,
  input  logic [PHYS_REG_IDX_SZ:0] free_pr_idx,
  input  logic                     retire_alloc_enable,
  input  logic                     restore_enable,
  output logic [PTR_W-1:0]         free_count,
  output logic                     overflow
);

  localparam int IDX_W = PTR_W - 1;

  logic [PHYS_REG_IDX_SZ:0] entries [FL_SZ];
  logic [PTR_W-1:0]         head;
  logic [PTR_W-1:0]         tail;
  logic [PTR_W-1:0]         retired_head;
  logic [PTR_W-1:0]         head_nxt;
  logic [PTR_W-1:0]         tail_nxt;
  logic [PTR_W-1:0]         retired_head_nxt;
  logic                     full;
  logic                     grant;
  logic                     free_req;
  logic                     free_ok;
  logic                     free_drop;

  // Wrap bit disambiguates full from empty when the index bits match.
  assign free_count   = tail - head;
  assign full         = (head[IDX_W-1:0] == tail[IDX_W-1:0]) && (head[PTR_W-1] != tail[PTR_W-1]);
  assign alloc_valid  = (free_count != '0);
  assign alloc_pr_idx = entries[head[IDX_W-1:0]];

  assign grant     = alloc_req && alloc_valid && !restore_enable;
  assign free_req  = free_enable && (free_pr_idx != ZERO_REG);
  assign free_ok   = free_req && !full;
  assign free_drop = free_req && full;

  always_comb begin
    retired_head_nxt = retired_head + PTR_W'(retire_alloc_enable);
    tail_nxt         = tail + PTR_W'(free_ok);
    if (restore_enable) begin
      head_nxt = retired_head_nxt;
    end else begin
      head_nxt = head + PTR_W'(grant);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head         <= '0;
      retired_head <= '0;
      tail         <= PTR_W'(FL_SZ - 1);
      overflow     <= 1'b0;
    end else begin
      head         <= head_nxt;
      retired_head <= retired_head_nxt;
      tail         <= tail_nxt;
      if (free_drop) begin
        overflow <= 1'b1;
      end
    end
  end

  // After reset every register except the zero register is free, in ascending order.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < FL_SZ; i++) begin
        entries[i] <= (i == FL_SZ - 1) ? ZERO_REG : PR_W'(i + 1);
      end
    end else if (free_ok) begin
      entries[tail[IDX_W-1:0]] <= free_pr_idx;
    end
  end

endmodule

// File: doc/free_list.md
FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 SHALL have parameter FL_SZ, default `PHYS_REG_SZ (64); physical registers managed, power of two.
REQ-002 SHALL have parameter PTR_W, default $clog2(FL_SZ)+1 (7); pointer width including wrap bit.
REQ-003 SHALL have port clk  in  1  clock; all state updates on posedge.
REQ-004 SHALL have port reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port alloc_req  in  1  dispatch requests one PR this cycle.
REQ-006 SHALL have port alloc_valid  out  1  a free PR is available (count != 0).
REQ-007 SHALL have port alloc_pr_idx  out  `PHYS_REG_IDX_SZ+1  PR at head; feeds map-table new_dest_pr_idx.
REQ-008 SHALL have port free_enable  in  1  retiring instruction returns its old dest PR.
REQ-009 SHALL have port free_pr_idx  in  `PHYS_REG_IDX_SZ+1  PR being returned.
REQ-010 SHALL have port retire_alloc_enable  in  1  retiring instruction had allocated a PR; advances retired head.
REQ-011 SHALL have port restore_enable  in  1  mispredict rollback to retired state.
REQ-012 SHALL have port free_count  out  PTR_W  number of free PRs.
REQ-013 SHALL have port overflow  out  1  sticky error: free attempted while full.

Function
REQ-014 SHALL store FL_SZ entries in a circular buffer with head, tail, retired_head pointers of PTR_W bits; index = low bits, wrap = MSB.
REQ-015 SHALL drive alloc_pr_idx = entries[head] and alloc_valid = (free_count != 0) combinationally from registered state; no free-to-alloc bypass.
REQ-016 SHALL grant when alloc_req && alloc_valid && !restore_enable; head += 1 next cycle; alloc_req with alloc_valid=0 has no effect.
REQ-017 SHALL, on free_enable with free_pr_idx != 0 and free_count < FL_SZ, write entries[tail] <= free_pr_idx and tail += 1.
REQ-018 SHALL ignore free_enable with free_pr_idx == 0 (zero register never freed).
REQ-019 SHALL ignore free_enable when free_count == FL_SZ and set overflow <= 1 until reset.
REQ-020 SHALL advance retired_head by 1 on retire_alloc_enable, regardless of restore_enable.
REQ-021 SHALL, on restore_enable, set head <= retired_head plus 1 if retire_alloc_enable the same cycle; grant suppressed; a same-cycle free still applies to tail.
REQ-022 SHALL compute free_count = tail - head modulo 2^PTR_W; full when index equal and wrap bits differ, empty when equal.
REQ-023 SHALL permit simultaneous grant and free: head and tail both advance, count unchanged; when count == 0 only the free takes effect.
REQ-024 SHALL wrap pointers modulo 2^PTR_W with no special-case logic at FL_SZ-1 -> 0.
REQ-025 SHALL produce one-cycle latency: a PR freed in cycle N is allocatable from cycle N+1.

Reset
REQ-026 SHALL on reset set entries[i] = i+1 for i = 0..FL_SZ-2, entries[FL_SZ-1] = 0; head = 0, retired_head = 0, tail = FL_SZ-1, overflow = 0.
REQ-027 SHALL therefore present after reset alloc_valid = 1, alloc_pr_idx = 1, free_count = FL_SZ-1 (63).
REQ-028 SHALL give reset priority over all other inputs, including mid-restore and mid-alloc.

Structure
REQ-029 SHALL take `PHYS_REG_SZ, `PHYS_REG_IDX_SZ, `ZERO_REG from the shared sys_defs header; no new typedefs.
REQ-030 SHALL add FL_PTR_W to the shared package if other blocks (ROB checkpointing) consume pointers.
REQ-031 SHALL be a single module with no sub-modules; the pointer/count logic is simple enough inline.
REQ-032 SHALL provide a DEBUG_PRINT negedge dump of head, tail, retired_head, count and entries.

Verification
REQ-033 SHALL test reset then 63 consecutive alloc_req -> PRs 1..63 in order, alloc_valid = 0 after the 63rd, free_count = 0.
REQ-034 SHALL test empty list with alloc_req=1 and free_enable=1, free_pr_idx=5 -> no grant that cycle; next cycle alloc_pr_idx=5, alloc_valid=1.
REQ-035 SHALL test 3 allocs (PRs 1,2,3), 1 retire_alloc_enable, then restore_enable -> head back to 1, alloc_pr_idx=2, free_count=62.
REQ-036 SHALL test free_enable of PR 9 while free_count=64 -> ignored, overflow=1, sticky until reset.
REQ-037 SHALL test free_pr_idx=0 -> no change to tail or count; continuous alloc+free for 200 cycles -> count stays constant across wrap-around.
